// File: rtl/pong_pkg.sv
// Shared timing package: phase enumeration and default 640x480@60 constants.
// Imported by vga_timing_axis and vga_sync_gen.
package pong_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC        = 2;

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: 10-bit counter, ACTIVE/FP/SYNC/BP phase FSM,
// registered active-low sync, and a combinational wrap flag.
// Ports: clk, reset (sync, active-high), step (advance), count,
// phase_nxt (phase after this edge), sync (low in SYNC), wrap.
module vga_timing_axis
  import pong_pkg::*;
#(
  parameter int N_TOTAL  = DEF_TOTAL_COLS,
  parameter int N_ACTIVE = DEF_ACTIVE_COLS,
  parameter int N_FP     = DEF_H_FRONT_PORCH,
  parameter int N_SYNC   = DEF_H_SYNC
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] count,
  output phase_t     phase_nxt,
  output logic       sync,
  output logic       wrap
);

  localparam logic [9:0] LAST  = 10'(N_TOTAL - 1);
  localparam logic [9:0] A_END = 10'(N_ACTIVE - 1);
  localparam logic [9:0] F_END = 10'(N_ACTIVE + N_FP - 1);
  localparam logic [9:0] S_END = 10'(N_ACTIVE + N_FP + N_SYNC - 1);

  phase_t phase;

  // Next phase is exposed so the owner can register decodes
  // that line up with the count of the same edge.
  always_comb begin
    wrap      = step && (count == LAST);
    phase_nxt = phase;
    if (step) begin
      unique case (phase)
        ACTIVE: if (count == A_END) phase_nxt = FP;
        FP:     if (count == F_END) phase_nxt = SYNC;
        SYNC:   if (count == S_END) phase_nxt = BP;
        BP:     if (count == LAST)  phase_nxt = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= ACTIVE;
      sync  <= 1'b1;
    end else if (step) begin
      count <= wrap ? '0 : count + 10'd1;
      phase <= phase_nxt;
      sync  <= (phase_nxt != SYNC);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: horizontal axis stepped by i_Enable, vertical axis
// stepped by the horizontal wrap. All outputs registered and coherent.
// Ports: i_Clk, i_Reset (sync, active-high), i_Enable (pixel tick),
// o_HSync/o_VSync (active-low), o_Col_Count/o_Row_Count, o_Active,
// o_Line_Start/o_Frame_Start (1-cycle pulses), o_Frame_Count.
// Optional: define VGA_SYNC_GEN_FRAME_CNT_EN for a wrapping 8-bit frame
// counter; otherwise o_Frame_Count is tied to 0.
module vga_sync_gen
  import pong_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC        = DEF_V_SYNC
)(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count
);

  phase_t h_nxt;
  phase_t v_nxt;
  logic   h_wrap;
  logic   v_wrap;

  vga_timing_axis #(
    .N_TOTAL  (TOTAL_COLS),
    .N_ACTIVE (ACTIVE_COLS),
    .N_FP     (H_FRONT_PORCH),
    .N_SYNC   (H_SYNC)
  ) u_h (
    .clk       (i_Clk),
    .reset     (i_Reset),
    .step      (i_Enable),
    .count     (o_Col_Count),
    .phase_nxt (h_nxt),
    .sync      (o_HSync),
    .wrap      (h_wrap)
  );

  vga_timing_axis #(
    .N_TOTAL  (TOTAL_ROWS),
    .N_ACTIVE (ACTIVE_ROWS),
    .N_FP     (V_FRONT_PORCH),
    .N_SYNC   (V_SYNC)
  ) u_v (
    .clk       (i_Clk),
    .reset     (i_Reset),
    .step      (h_wrap),
    .count     (o_Row_Count),
    .phase_nxt (v_nxt),
    .sync      (o_VSync),
    .wrap      (v_wrap)
  );

  // Pulses follow the wrap flags directly, so they drop on the
  // next edge whether or not i_Enable is still high.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Active      <= 1'b1;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Line_Start  <= h_wrap;
      o_Frame_Start <= h_wrap && v_wrap;
      if (i_Enable)
        o_Active <= (h_nxt == ACTIVE) && (v_nxt == ACTIVE);
    end
  end

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      o_Frame_Count <= '0;
    else if (h_wrap && v_wrap)
      o_Frame_Count <= o_Frame_Count + 8'd1;
  end
`else
  assign o_Frame_Count = '0;
`endif

endmodule
